// File: rtl/d_ff.sv
`default_nettype none
// ============================================================================
//  Module   : d_ff
//  Purpose  : Parameterizable rising-edge D register with synchronous
//             active-low reset and active-high capture enable. Basic storage
//             cell for pipeline registers (one cell per bit or per field).
//  Revision : 1.0 - initial release
// ============================================================================
module d_ff #(
  parameter int unsigned            WIDTH     = 1,
  parameter logic [WIDTH-1:0]       RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage: reset has priority over enable, enable over hold; q comes
  // straight from the flops so there is no path from d/en/reset to q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_d_ff.sv
`default_nettype none
// ============================================================================
//  Module   : tb_d_ff
//  Purpose  : Self-checking bench for d_ff at several widths / reset values,
//             directed scenarios plus randomized stimulus against a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_d_ff;

  localparam logic [4:0] RV5 = 5'd30;
  localparam logic [7:0] RV8 = 8'h5A;

  logic        clk;
  logic        reset;
  logic        en;
  logic [0:0]  d1;
  logic [4:0]  d5;
  logic [7:0]  d8;
  logic [63:0] d64;
  logic [0:0]  q1;
  logic [4:0]  q5;
  logic [7:0]  q8;
  logic [63:0] q64;

  // reference state: value each register should hold
  logic [0:0]  m1;
  logic [4:0]  m5;
  logic [7:0]  m8;
  logic [63:0] m64;

  int checks   = 0;
  int failures = 0;

  d_ff #(.WIDTH(1),  .RESET_VAL(1'b0))  u_w1  (.clk(clk), .reset(reset), .en(en), .d(d1),  .q(q1));
  d_ff #(.WIDTH(5),  .RESET_VAL(RV5))   u_w5  (.clk(clk), .reset(reset), .en(en), .d(d5),  .q(q5));
  d_ff #(.WIDTH(8),  .RESET_VAL(RV8))   u_w8  (.clk(clk), .reset(reset), .en(en), .d(d8),  .q(q8));
  d_ff #(.WIDTH(64), .RESET_VAL(64'd0)) u_w64 (.clk(clk), .reset(reset), .en(en), .d(d64), .q(q64));

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // compare every register with the model (no edge involved)
  task automatic check_all(input string tag);
    check({tag, ".q1"},  {127'd0, q1},  {127'd0, m1});
    check({tag, ".q5"},  {123'd0, q5},  {123'd0, m5});
    check({tag, ".q8"},  {120'd0, q8},  {120'd0, m8});
    check({tag, ".q64"}, {64'd0, q64},  {64'd0, m64});
  endtask

  // one rising edge: apply the register rule to the model, then check 1 unit later
  task automatic tick(input string tag);
    @(posedge clk);
    if (!reset) begin
      m1 = 1'b0; m5 = RV5; m8 = RV8; m64 = 64'd0;
    end else if (en) begin
      m1 = d1; m5 = d5; m8 = d8; m64 = d64;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] pat;
    reset = 1'b0; en = 1'b1; d1 = 1'b1; d5 = '0; d8 = '0; d64 = '0;

    // T1: reset for one edge with d=1, then q follows d 0,1,0,1
    tick("t1_reset");
    reset = 1'b1;
    pat = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      d1 = pat[i];
      tick("t1_follow");
    end

    // T2: 64-bit values 0,100,200,300 then i*25
    for (int i = 0; i < 4; i++) begin
      d64 = 64'(i * 100);
      tick("t2_seq");
    end
    for (int i = 0; i < 10; i++) begin
      d64 = 64'(i * 25);
      tick("t2_mul");
    end

    // T3: capture, hold for 3 edges with en=0, then capture 0
    d64 = 64'hDEADBEEF_CAFEF00D;
    tick("t3_cap");
    en = 1'b0; d64 = '0;
    for (int i = 0; i < 3; i++) tick("t3_hold");
    en = 1'b1;
    tick("t3_resume");

    // T4: mid-cycle reset assert/deassert acts only at the next edge
    d5 = 5'd7;
    tick("t4_load7");
    #2 reset = 1'b0;
    #1 check_all("t4_mid_assert");
    tick("t4_reset30");
    #2 reset = 1'b1; en = 1'b1; d5 = 5'd12;
    #1 check_all("t4_mid_release");
    tick("t4_load12");

    // T5: reset beats enable; d glitches between edges are invisible
    reset = 1'b0; en = 1'b0; d8 = 8'hFF;
    tick("t5_rst_over_en");
    reset = 1'b1; en = 1'b1;
    d8 = 8'h11; #1 check_all("t5_glitch_a");
    d8 = 8'h22; #1 check_all("t5_glitch_b");
    d8 = 8'h33;
    tick("t5_edge");

    // Randomized: reset asserted ~1/8 of edges, enable ~3/4, with glitches
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(7) != 0);
      en    = ($urandom_range(3) != 0);
      d1    = 1'($urandom);
      d5    = 5'($urandom);
      d8    = 8'($urandom);
      d64   = {$urandom, $urandom};
      if ($urandom_range(3) == 0) begin
        #2 check_all("rnd_mid");
        d8 = 8'($urandom); d64 = {$urandom, $urandom};
      end
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
